// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data port between core and responder.
// master = core (addresses, write data, strobe); slave = responder (rdata, hazard).
interface dmem_responder_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
);
  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr;
  logic [DATA_WIDTH-1:0]      data_mem_rdata;
  logic                       data_mem_hazard;
  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr;
  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata;
  logic                       cpu_data_mem_write;

  modport master (
    output cpu_data_mem_raddr,
    output cpu_data_mem_waddr,
    output cpu_data_mem_wdata,
    output cpu_data_mem_write,
    input  data_mem_rdata,
    input  data_mem_hazard
  );

  modport slave (
    input  cpu_data_mem_raddr,
    input  cpu_data_mem_waddr,
    input  cpu_data_mem_wdata,
    input  cpu_data_mem_write,
    output data_mem_rdata,
    output data_mem_hazard
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed SRAM model with LATENCY-cycle access, a one-word
// read line and a one-entry posted write buffer; stalls the core via hazard.
// Ports: cpu_clk, cpu_rst (async, active-high), bus (dmem_responder_if.slave).
// Optional: define DMEM_WRITE_FORWARD_EN to serve reads from the write buffer.
module dmem_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 3
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  dmem_responder_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    DRAIN     = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic                  line_valid_q, line_valid_d;
  logic [DEPTH_LOG2-1:0] line_idx_q, line_idx_d;
  logic [DATA_WIDTH-1:0] line_data_q, line_data_d;

  logic                  wbuf_valid_q, wbuf_valid_d;
  logic [DEPTH_LOG2-1:0] wbuf_idx_q, wbuf_idx_d;
  logic [DATA_WIDTH-1:0] wbuf_data_q, wbuf_data_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;

  // Address decode
  logic [DATA_ADDR_WIDTH-1:0] raddr;
  logic [DATA_ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [DEPTH_LOG2-1:0]      r_idx;
  logic [DEPTH_LOG2-1:0]      w_idx;
  logic                       r_inr;
  logic                       w_inr;

  assign raddr = bus.cpu_data_mem_raddr;
  assign waddr = bus.cpu_data_mem_waddr;
  assign wdata = bus.cpu_data_mem_wdata;

  assign r_idx = raddr[DEPTH_LOG2+1:2];
  assign w_idx = waddr[DEPTH_LOG2+1:2];
  assign r_inr = (raddr[DATA_ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign w_inr = (waddr[DATA_ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);

  // Byte-lane bits carry no meaning for a word array.
  logic unused_lsb;
  assign unused_lsb = ^{raddr[1:0], waddr[1:0]};

  // Request classification
  logic wr;
  logic wr_accept;
  logic wr_stall;
  logic rd;
  logic line_hit;
  logic wbuf_match;
  logic fwd_hit;
  logic conflict;
  logic rd_hit;
  logic rd_miss;

  assign wr        = bus.cpu_data_mem_write;
  assign wr_accept = wr & w_inr & ~wbuf_valid_q;
  assign wr_stall  = wr & w_inr & wbuf_valid_q;
  assign rd        = ~wr & r_inr;

  assign line_hit   = line_valid_q & (line_idx_q == r_idx);
  assign wbuf_match = wbuf_valid_q & (wbuf_idx_q == r_idx);

`ifdef DMEM_WRITE_FORWARD_EN
  // Buffered word is newest: it wins over the line.
  assign fwd_hit  = rd & wbuf_match;
  assign conflict = 1'b0;
`else
  // Reads of the buffered word wait for the drain to land.
  assign fwd_hit  = 1'b0;
  assign conflict = rd & wbuf_match;
`endif

  assign rd_hit  = rd & ~conflict & (fwd_hit | line_hit);
  assign rd_miss = rd & ~conflict & ~fwd_hit & ~line_hit;

  // Outputs are forced quiet while reset is held.
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (!cpu_rst && rd_hit) begin
      rdata = fwd_hit ? wbuf_data_q : line_data_q;
    end
  end

  assign bus.data_mem_rdata  = rdata;
  assign bus.data_mem_hazard = ~cpu_rst & (wr_stall | (rd & ~rd_hit));

  // Next state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_valid_d = line_valid_q;
    line_idx_d   = line_idx_q;
    line_data_d  = line_data_q;
    wbuf_valid_d = wbuf_valid_q;
    wbuf_idx_d   = wbuf_idx_q;
    wbuf_data_d  = wbuf_data_q;
    mem_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A write accepted this cycle starts draining on the next one.
        if (rd_miss) begin
          state_d = READ_WAIT;
          cnt_d   = CNT_INIT;
        end else if (wbuf_valid_q || wr_accept) begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
        end
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          line_valid_d = 1'b1;
          line_idx_d   = r_idx;
          line_data_d  = mem[r_idx];
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          mem_we       = 1'b1;
          wbuf_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture keeps the line coherent with the posted write.
    if (wr_accept) begin
      wbuf_valid_d = 1'b1;
      wbuf_idx_d   = w_idx;
      wbuf_data_d  = wdata;
      if (line_valid_q && (line_idx_q == w_idx)) begin
        line_data_d = wdata;
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_valid_q <= 1'b0;
      line_idx_q   <= '0;
      line_data_q  <= '0;
      wbuf_valid_q <= 1'b0;
      wbuf_idx_q   <= '0;
      wbuf_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_valid_q <= line_valid_d;
      line_idx_q   <= line_idx_d;
      line_data_q  <= line_data_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_idx_q   <= wbuf_idx_d;
      wbuf_data_q  <= wbuf_data_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge cpu_clk) begin
    if (mem_we) begin
      mem[wbuf_idx_q] <= wbuf_data_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LATENCY=3).
// Expected read data comes from a shadow memory and is queued at issue.
module tb_dmem_responder;

  localparam logic [31:0] IDLE_A = 32'hFFFF_0000;

`ifdef DMEM_WRITE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;

  dmem_responder_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) bus ();

  dmem_responder #(
    .DATA_WIDTH(32),
    .DATA_ADDR_WIDTH(32),
    .DEPTH_LOG2(10),
    .LATENCY(3)
  ) dut (
    .cpu_clk(clk),
    .cpu_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a[31:12] == 20'd0;
  endfunction

  task automatic idle(input int n);
    bus.cpu_data_mem_write = 1'b0;
    bus.cpu_data_mem_raddr = IDLE_A;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input int exp_stall);
    int st;
    bus.cpu_data_mem_raddr = IDLE_A;
    bus.cpu_data_mem_waddr = a;
    bus.cpu_data_mem_wdata = d;
    bus.cpu_data_mem_write = 1'b1;
    st = 0;
    @(negedge clk);
    while (bus.data_mem_hazard && st < 40) begin
      st++;
      @(negedge clk);
    end
    check({tag, ".stall"}, st, exp_stall);
    if (in_range(a)) model[int'(a[11:2])] = d;
    @(posedge clk);
    #1;
    bus.cpu_data_mem_write = 1'b0;
    bus.cpu_data_mem_raddr = IDLE_A;
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input int exp_stall);
    int st;
    logic [31:0] got;
    if (in_range(a)) exp_q.push_back(model[int'(a[11:2])]);
    else exp_q.push_back(32'h0);
    bus.cpu_data_mem_write = 1'b0;
    bus.cpu_data_mem_raddr = a;
    st = 0;
    @(negedge clk);
    while (bus.data_mem_hazard && st < 40) begin
      st++;
      @(negedge clk);
    end
    got = bus.data_mem_rdata;
    check({tag, ".stall"}, st, exp_stall);
    check({tag, ".data"}, got, exp_q.pop_front());
    @(posedge clk);
    #1;
    bus.cpu_data_mem_raddr = IDLE_A;
  endtask

  task automatic rst_pulse();
    bus.cpu_data_mem_write = 1'b0;
    bus.cpu_data_mem_raddr = IDLE_A;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cpu_data_mem_raddr = 32'h40;
    bus.cpu_data_mem_waddr = 32'h0;
    bus.cpu_data_mem_wdata = 32'h0;
    bus.cpu_data_mem_write = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.hazard", {31'd0, bus.data_mem_hazard}, 32'd0);
    check("rst.rdata", bus.data_mem_rdata, 32'h0);
    bus.cpu_data_mem_raddr = IDLE_A;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Preload mem[16], then reset: array keeps it, line is cleared
    wr("pre40", 32'h40, 32'h1234_5678, 0);
    idle(4);
    rst_pulse();
    rd("miss40", 32'h40, 4);
    rd("hit40", 32'h40, 0);

    // Store then immediate load of the same word
    wr("st80", 32'h80, 32'hDEAD_BEEF, 0);
    rd("ld80", 32'h80, FWD ? 0 : 7);
    idle(4);

    // Back-to-back stores: second waits for the drain
    wr("st100", 32'h100, 32'hA1A1_0001, 0);
    wr("st104", 32'h104, 32'hA2A2_0002, 3);
    idle(4);
    rd("ld100", 32'h100, 4);
    rd("ld104", 32'h104, 4);
    rd("ld100b", 32'h100, 4);

    // Out-of-range read and write
    rd("oor_rd", IDLE_A, 0);
    wr("st0", 32'h0, 32'h0BAD_F00D, 0);
    wr("oor_wr", IDLE_A, 32'h5555_5555, 0);
    idle(4);
    rd("ld0", 32'h0, 4);

    // Reset in the middle of READ_WAIT
    wr("st200", 32'h200, 32'h2468_ACE0, 0);
    idle(4);
    bus.cpu_data_mem_raddr = 32'h200;
    @(negedge clk);
    check("rw.pre_hz", {31'd0, bus.data_mem_hazard}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rw.rst_hz", {31'd0, bus.data_mem_hazard}, 32'd0);
    check("rw.rst_rd", bus.data_mem_rdata, 32'h0);
    bus.cpu_data_mem_raddr = IDLE_A;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd("rw.again", 32'h200, 4);
    rd("rw.hit", 32'h200, 0);

    // Miss arriving while a drain is in flight
    wr("st300", 32'h300, 32'h1357_9BDF, 0);
    rd("drain_miss", 32'h40, 7);
    rd("ld300", 32'h300, 4);

    // Store to the line-resident word keeps the line coherent
    wr("st300b", 32'h300, 32'hCAFE_F00D, 0);
    rd("ld300b", 32'h300, FWD ? 0 : 3);
    idle(4);
    rd("ld300c", 32'h300, 0);

    check("sb.empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core's MEM-stage port. It answers the core's read address, write address, write data and write strobe with read data and a stall (hazard) flag. It holds a word-addressed SRAM model with a fixed multi-cycle access latency. A one-word read line and a one-entry posted write buffer hide that latency where possible.

## Interface
- `DATA_WIDTH`, 32, data word width
- `DATA_ADDR_WIDTH`, 32, byte-address width
- `DEPTH_LOG2`, 10, log2 of array depth in words
- `LATENCY`, 3, backing-array access cycles; legal range ≥1

- `cpu_clk`  in  1  sole clock, rising edge
- `cpu_rst`  in  1  asynchronous, active-high reset
- `cpu_data_mem_raddr`  in  DATA_ADDR_WIDTH  read byte address, evaluated every cycle
- `data_mem_rdata`  out  DATA_WIDTH  read data, valid when `data_mem_hazard`=0
- `data_mem_hazard`  out  1  stall request to the core
- `cpu_data_mem_waddr`  in  DATA_ADDR_WIDTH  write byte address
- `cpu_data_mem_wdata`  in  DATA_WIDTH  write data
- `cpu_data_mem_write`  in  1  write strobe

## Operation
- **Address decode.** Word index is `addr[DEPTH_LOG2+1:2]`; `addr[1:0]` are ignored. An address is in range iff `addr[DATA_ADDR_WIDTH-1:DEPTH_LOG2+2]`==0.
- **Registers.**
  - Read line: `line_valid`, `line_idx`, `line_data`.
  - Write buffer: `wbuf_valid`, `wbuf_idx`, `wbuf_data`.
  - Down-counter `cnt`.
  - FSM with states IDLE, READ_WAIT, DRAIN.
- **Write cycle** (`cpu_data_mem_write`=1). The read side is ignored.
  - Out of range: the write is dropped and hazard=0.
  - In range with `wbuf_valid`=0: the write is captured into the buffer and hazard=0. If `line_valid` and `line_idx` match, `line_data` is updated in the same edge.
  - In range with `wbuf_valid`=1: hazard=1 until the buffer drains. The write is then captured.
- **Read cycle.**
  - Out of range: rdata=0, hazard=0.
  - Hit (`line_valid` and `line_idx`==idx): rdata=`line_data`, hazard=0.
  - Otherwise: miss, hazard=1.
- **FSM transitions.**
  - IDLE → READ_WAIT on a read miss, loading `cnt`=LATENCY-1. A pending miss has priority over a drain.
  - IDLE → DRAIN when `wbuf_valid`=1 and there is no miss, loading `cnt`=LATENCY-1.
  - READ_WAIT: decrement `cnt`. At `cnt`==0, load the line with the array word at idx, set `line_valid`, and go to IDLE.
  - DRAIN: decrement `cnt`. At `cnt`==0, write `wbuf_data` into the array at `wbuf_idx`, clear `wbuf_valid`, and go to IDLE.
- **Hazard outside IDLE.** hazard=1 for any in-range request that is not a hit, and for any write while `wbuf_valid`=1.
- **Requester contract.** While hazard=1, all core inputs are held stable.
- **Reset (asynchronous, any state).**
  - FSM → IDLE, `cnt`=0, `line_valid`=0, `wbuf_valid`=0. A buffered write is discarded.
  - While `cpu_rst`=1: `data_mem_hazard`=0 and `data_mem_rdata`=0.
  - Array contents are not reset.

## Timing
- Read hit: zero latency; combinational rdata in the same cycle, no stall.
- Read miss first presented in cycle t: hazard=1 in cycles t..t+LATENCY. Data is returned with hazard=0 in cycle t+LATENCY+1.
- Miss during DRAIN: the stall adds the remaining drain cycles plus 1 before READ_WAIT starts.
- Write accepted in cycle t with buffer empty: drain occupies t+1..t+LATENCY when no miss intervenes. The buffer is free at the start of cycle t+LATENCY+1.
- LATENCY=1: READ_WAIT and DRAIN each last one cycle.

## Configuration
- `DMEM_WRITE_FORWARD_EN` defined:
  - A read whose idx equals `wbuf_idx` while `wbuf_valid`=1 is a hit.
  - rdata=`wbuf_data`, hazard=0.
  - The write buffer is checked before the line.
- Undefined:
  - Such a read asserts hazard=1 until the drain completes.
  - It is then evaluated normally: a hit if the line matches, otherwise a miss.

## Test plan
- Reset, then release; LATENCY=3, mem[16]=0x1234_5678, read 0x40 → hazard=1 for 4 cycles, then rdata=0x1234_5678 with hazard=0.
- Read 0x40 again → hazard=0 immediately, rdata=0x1234_5678.
- Store 0xDEADBEEF to 0x80 at t, load 0x80 at t+1 → with `DMEM_WRITE_FORWARD_EN`: hazard=0, rdata=0xDEADBEEF. Without it: hazard through t+3, then a 4-cycle miss, then rdata=0xDEADBEEF.
- Stores to 0x100 at t and 0x104 at t+1 → second store has hazard=1 in t+1..t+3, is accepted at t+4; final array holds both words.
- Read 0xFFFF_0000 → rdata=0, hazard=0. Store to 0xFFFF_0000 → hazard=0, array unchanged.
- Assert `cpu_rst` mid-READ_WAIT → hazard=0 and rdata=0 immediately. After release, the same read takes the full LATENCY+1 stall.
